// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: EX/ID-stage request and HI/LO result bundle for the multiply/divide controller.
interface mdu_ctrl_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, d_use, input busy, stall, hi, lo);
   modport slave  (input start, op, a, b, d_use, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning HI/LO and the ID-stage stall request.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops (6..9).
module mdu_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic      clk,
   input  logic      rst,
   mdu_ctrl_if.slave bus
);
   localparam int unsigned CW = 4;
   localparam int unsigned DW = 32;
   localparam logic [DW-1:0] ZERO = '0;

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd6;
   localparam logic [3:0] OP_MADDU = 4'd7;
   localparam logic [3:0] OP_MSUB  = 4'd8;
   localparam logic [3:0] OP_MSUBU = 4'd9;
`endif

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            busy_q, busy_n;
   logic [DW-1:0]   hi_q, hi_n, lo_q, lo_n;
   logic [DW-1:0]   a_q, b_q;
   logic [3:0]      op_q;
   logic            ld;
   logic            is_mul, is_div;

   // Operation class decode of the EX-stage request
`ifdef MDU_MADD_EN
   assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                   ((bus.op >= OP_MADD) && (bus.op <= OP_MSUBU));
`else
   assign is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`endif
   assign is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);

   // Multiply datapath on latched operands; accumulate reads HI/LO at completion
   logic            mul_signed;
   logic [2*DW-1:0] ext_a, ext_b, prod, mul_res;
`ifdef MDU_MADD_EN
   assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
`else
   assign mul_signed = (op_q == OP_MULT);
`endif
   assign ext_a = {{DW{mul_signed & a_q[DW-1]}}, a_q};
   assign ext_b = {{DW{mul_signed & b_q[DW-1]}}, b_q};
   assign prod  = ext_a * ext_b;

   always_comb begin
      mul_res = prod;
`ifdef MDU_MADD_EN
      if ((op_q == OP_MADD) || (op_q == OP_MADDU))
         mul_res = {hi_q, lo_q} + prod;
      else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
         mul_res = {hi_q, lo_q} - prod;
`endif
   end

   // Divide via magnitudes so the most-negative dividend needs no special case
   logic          div_neg_a, div_neg_b;
   logic [DW-1:0] mag_a, mag_b, uq, ur, quo, rem;
   assign div_neg_a = (op_q == OP_DIV) & a_q[DW-1];
   assign div_neg_b = (op_q == OP_DIV) & b_q[DW-1];
   assign mag_a     = div_neg_a ? ZERO - a_q : a_q;
   assign mag_b     = div_neg_b ? ZERO - b_q : b_q;
   assign uq        = mag_a / mag_b;
   assign ur        = mag_a % mag_b;
   assign quo       = (div_neg_a ^ div_neg_b) ? ZERO - uq : uq;
   assign rem       = div_neg_a ? ZERO - ur : ur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         busy_q <= busy_n;
         hi_q   <= hi_n;
         lo_q   <= lo_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q  <= '0;
         b_q  <= '0;
         op_q <= '0;
      end else if (ld) begin
         a_q  <= bus.a;
         b_q  <= bus.b;
         op_q <= bus.op;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      busy_n  = busy_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      ld      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (is_mul) begin
                  ld      = 1'b1;
                  cnt_n   = CW'(MUL_CYCLES - 1);
                  state_n = MUL;
                  busy_n  = 1'b1;
               end else if (is_div) begin
                  ld      = 1'b1;
                  cnt_n   = CW'(DIV_CYCLES - 1);
                  state_n = DIV;
                  busy_n  = 1'b1;
               end else if (bus.op == OP_MTHI) begin
                  hi_n = bus.a;
               end else if (bus.op == OP_MTLO) begin
                  lo_n = bus.a;
               end
            end
         end
         MUL: begin
            if (cnt == '0) begin
               {hi_n, lo_n} = mul_res;
               state_n      = IDLE;
               busy_n       = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         DIV: begin
            if (cnt == '0) begin
               // Divide by zero keeps the full latency but leaves HI/LO untouched
               if (b_q != '0) begin
                  hi_n = rem;
                  lo_n = quo;
               end
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt - CW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   assign bus.busy  = busy_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.stall = bus.d_use & (busy_q | bus.start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; expected HI/LO and latency come from a behavioural model.
module tb_mdu_ctrl;
   localparam int unsigned MUL_L = 5;
   localparam int unsigned DIV_L = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mdu_ctrl_if bus();

   mdu_ctrl #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;
   int          vectors = 0;
   int          miscompares = 0;

   // Behavioural model: 64-bit integer arithmetic, pushes expected HI/LO and busy length
   task automatic predict(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      x, y, q, r;
      logic [63:0] p;
      e.lat = 0;
      x = longint'($signed(a));
      y = longint'($signed(b));
      case (op)
         4'd0: begin p = 64'(x * y); {mhi, mlo} = p; e.lat = MUL_L; end
         4'd1: begin p = {32'd0, a} * {32'd0, b}; {mhi, mlo} = p; e.lat = MUL_L; end
         4'd2: begin
            if (b != 32'd0) begin q = x / y; r = x % y; mlo = q[31:0]; mhi = r[31:0]; end
            e.lat = DIV_L;
         end
         4'd3: begin
            if (b != 32'd0) begin mlo = a / b; mhi = a % b; end
            e.lat = DIV_L;
         end
         4'd4: mhi = a;
         4'd5: mlo = a;
`ifdef MDU_MADD_EN
         4'd6, 4'd7, 4'd8, 4'd9: begin
            if (op == 4'd6 || op == 4'd8) p = 64'(x * y);
            else                          p = {32'd0, a} * {32'd0, b};
            if (op <= 4'd7) {mhi, mlo} = {mhi, mlo} + p;
            else            {mhi, mlo} = {mhi, mlo} - p;
            e.lat = MUL_L;
         end
`endif
         default: ;
      endcase
      e.hi = mhi;
      e.lo = mlo;
      sb.push_back(e);
   endtask

   // Called at a negedge: start is held for exactly one rising edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      predict(op, a, b);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
   endtask

   task automatic wait_done(output int n, output bit to);
      n = 0; to = 1'b0;
      while (bus.busy === 1'b1 && !to) begin
         n++;
         if (n > 64) to = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e, output int n, output bit to);
      issue(op, a, b);
      wait_done(n, to);
      if (sb.size() > 0) e = sb.pop_front();
      else begin e.hi = 'x; e.lo = 'x; e.lat = -1; end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.d_use = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", bus.busy, bus.hi, bus.lo);
      end
      bus.d_use = 1'b1; #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall_idle: stall=%b want 0", bus.stall); end
      bus.start = 1'b1; #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall_start: stall=%b want 1", bus.stall); end
      bus.start = 1'b0; bus.d_use = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      mhi = '0; mlo = '0;
   endtask

   task automatic test_mult();
      exp_t e; int n; bit to;
      logic [3:0] op; logic [31:0] a, b;
      run_op(4'd0, 32'hFFFF_FFFE, 32'd3, e, n, to);
      vectors++;
      if (to || n !== MUL_L) begin miscompares++; $display("FAIL mult_busy: %0d cycles, want %0d", n, MUL_L); end
      vectors++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin
         miscompares++; $display("FAIL mult_neg2x3: got %h:%h want ffffffff:fffffffa", bus.hi, bus.lo);
      end
      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, e, n, to);
      vectors++;
      if (bus.hi !== 32'h2 || bus.lo !== 32'hFFFF_FFFA) begin
         miscompares++; $display("FAIL multu_neg2x3: got %h:%h want 00000002:fffffffa", bus.hi, bus.lo);
      end
      for (int i = 0; i < 6; i++) begin
         op = 4'(i % 2); a = $urandom; b = $urandom;
         run_op(op, a, b, e, n, to);
         vectors++;
         if (to || n !== e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            miscompares++;
            $display("FAIL mult_rand op%0d %h*%h: got %h:%h in %0d, want %h:%h in %0d",
                     op, a, b, bus.hi, bus.lo, n, e.hi, e.lo, e.lat);
         end
      end
   endtask

   task automatic test_div();
      exp_t e; int n; bit to;
      logic [3:0] op; logic [31:0] a, b;
      run_op(4'd2, 32'hFFFF_FFF9, 32'd2, e, n, to);
      vectors++;
      if (to || n !== DIV_L) begin miscompares++; $display("FAIL div_busy: %0d cycles, want %0d", n, DIV_L); end
      vectors++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
         miscompares++; $display("FAIL div_neg7by2: got %h:%h want ffffffff:fffffffd", bus.hi, bus.lo);
      end
      run_op(4'd3, 32'd7, 32'd0, e, n, to);
      vectors++;
      if (to || n !== DIV_L || bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
         miscompares++; $display("FAIL divu_by_zero: got %h:%h in %0d, want ffffffff:fffffffd in %0d",
                                 bus.hi, bus.lo, n, DIV_L);
      end
      run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, e, n, to);
      vectors++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
         miscompares++; $display("FAIL div_overflow: got %h:%h want 00000000:80000000", bus.hi, bus.lo);
      end
      for (int i = 0; i < 6; i++) begin
         op = 4'(2 + (i % 2)); a = $urandom; b = (i == 4) ? 32'd0 : ($urandom >> (i * 4));
         run_op(op, a, b, e, n, to);
         vectors++;
         if (to || n !== e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            miscompares++;
            $display("FAIL div_rand op%0d %h/%h: got %h:%h in %0d, want %h:%h in %0d",
                     op, a, b, bus.hi, bus.lo, n, e.hi, e.lo, e.lat);
         end
      end
   endtask

   task automatic test_mtlo_stall();
      exp_t e; int n; bit to;
      run_op(4'd5, 32'h1234, 32'd0, e, n, to);
      vectors++;
      if (n !== 0 || bus.busy !== 1'b0 || bus.lo !== 32'h1234 || bus.hi !== e.hi) begin
         miscompares++; $display("FAIL mtlo: got lo=%h hi=%h busy=%b n=%0d, want lo=00001234 hi=%h busy=0 n=0",
                                 bus.lo, bus.hi, bus.busy, n, e.hi);
      end
      bus.d_use = 1'b1; #1;
      vectors++;
      if (bus.stall !== 1'b0) begin miscompares++; $display("FAIL mflo_no_stall: stall=%b want 0", bus.stall); end
      @(negedge clk);
      bus.d_use = 1'b0;
   endtask

   task automatic test_stall_ignore();
      exp_t e; int n;
      bus.d_use = 1'b1;
      predict(4'd2, 32'hFFFF_FF9C, 32'd7);
      bus.start = 1'b1; bus.op = 4'd2; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7; #1;
      vectors++;
      if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL stall_start_cycle: stall=%b want 1", bus.stall); end
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.busy === 1'b1 && n < 64) begin
         n++;
         vectors++;
         if (bus.stall !== 1'b1) begin miscompares++; $display("FAIL stall_busy c%0d: stall=%b want 1", n, bus.stall); end
         if (n == 3) begin bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd5; bus.b = 32'd5; end
         else bus.start = 1'b0;
         @(negedge clk);
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (n !== DIV_L || bus.hi !== e.hi || bus.lo !== e.lo || bus.stall !== 1'b0) begin
         miscompares++; $display("FAIL stall_ignore: got %h:%h in %0d stall=%b, want %h:%h in %0d stall=0",
                                 bus.hi, bus.lo, n, bus.stall, e.hi, e.lo, DIV_L);
      end
      vectors++;
      if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'hFFFF_FFF2) begin
         miscompares++; $display("FAIL div_neg100by7: got %h:%h want fffffffe:fffffff2", bus.hi, bus.lo);
      end
      bus.d_use = 1'b0;
   endtask

   task automatic test_back_to_back();
      exp_t e; int n; bit to;
      logic [3:0] op; logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         op = 4'($urandom_range(0, 5)); a = $urandom; b = (i == 3) ? 32'd0 : $urandom;
         run_op(op, a, b, e, n, to);
         vectors++;
         if (to || n !== e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            miscompares++;
            $display("FAIL b2b #%0d op%0d: got %h:%h in %0d, want %h:%h in %0d",
                     i, op, bus.hi, bus.lo, n, e.hi, e.lo, e.lat);
         end
      end
   endtask

   task automatic test_madd();
      exp_t e; int n; bit to;
      logic [3:0] op; logic [31:0] a, b;
`ifdef MDU_MADD_EN
      run_op(4'd4, 32'd0, 32'd0, e, n, to);
      run_op(4'd5, 32'd5, 32'd0, e, n, to);
      run_op(4'd6, 32'd2, 32'd3, e, n, to);
      vectors++;
      if (to || n !== MUL_L || bus.hi !== 32'd0 || bus.lo !== 32'd11) begin
         miscompares++; $display("FAIL madd: got %h:%h in %0d, want 00000000:0000000b in %0d", bus.hi, bus.lo, n, MUL_L);
      end
      run_op(4'd9, 32'd1, 32'd20, e, n, to);
      vectors++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF7) begin
         miscompares++; $display("FAIL msubu: got %h:%h want ffffffff:fffffff7", bus.hi, bus.lo);
      end
      for (int i = 0; i < 8; i++) begin
         op = 4'(6 + (i % 4)); a = $urandom; b = $urandom;
         run_op(op, a, b, e, n, to);
         vectors++;
         if (to || n !== e.lat || bus.hi !== e.hi || bus.lo !== e.lo) begin
            miscompares++;
            $display("FAIL madd_rand op%0d: got %h:%h in %0d, want %h:%h in %0d",
                     op, bus.hi, bus.lo, n, e.hi, e.lo, e.lat);
         end
      end
`else
      run_op(4'd6, 32'd2, 32'd3, e, n, to);
      vectors++;
      if (n !== 0 || bus.busy !== 1'b0 || bus.hi !== e.hi || bus.lo !== e.lo) begin
         miscompares++; $display("FAIL madd_disabled: got %h:%h busy=%b n=%0d, want %h:%h busy=0 n=0",
                                 bus.hi, bus.lo, bus.busy, n, e.hi, e.lo);
      end
`endif
      for (int i = 0; i < 2; i++) begin
         op = 4'(10 + 3 * i); a = $urandom; b = $urandom;
         run_op(op, a, b, e, n, to);
         vectors++;
         if (n !== 0 || bus.busy !== 1'b0 || bus.hi !== e.hi || bus.lo !== e.lo) begin
            miscompares++; $display("FAIL unknown_op%0d: got %h:%h n=%0d, want %h:%h n=0",
                                    op, bus.hi, bus.lo, n, e.hi, e.lo);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e; int n; bit to;
      run_op(4'd4, 32'hDEAD_0001, 32'd0, e, n, to);
      run_op(4'd5, 32'hBEEF_0002, 32'd0, e, n, to);
      bus.start = 1'b1; bus.op = 4'd0; bus.a = 32'd7; bus.b = 32'd9;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: busy=%b want 1", bus.busy); end
      rst = 1'b1; #1;
      vectors++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         miscompares++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h, want 0/0/0", bus.busy, bus.hi, bus.lo);
      end
      @(negedge clk); rst = 1'b0;
      mhi = '0; mlo = '0; sb.delete();
      @(negedge clk);
      run_op(4'd4, 32'd1, 32'd0, e, n, to);
      vectors++;
      if (n !== 0 || bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
         miscompares++; $display("FAIL mthi_after_reset: got %h:%h n=%0d, want 00000001:00000000 n=0", bus.hi, bus.lo, n);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mtlo_stall();
      test_stall_ignore();
      test_back_to_back();
      test_madd();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
